// File: rtl/lvds_panel_seq_ctrl.sv
// rtl/lvds_panel_seq_ctrl.sv - LVDS panel power/link sequencer with frame-aligned video gating
module lvds_panel_seq_ctrl #(
   parameter int   T_VDD_LINK = 1000,
   parameter int   T_LINK_VID = 1000,
   parameter int   T_VID_BL   = 2000,
   parameter int   T_BL_VID   = 2000,
   parameter int   T_VID_LINK = 1000,
   parameter int   T_LINK_VDD = 1000,
   parameter int   T_OFF_MIN  = 5000,
   parameter int   CNT_W      = 24,
   parameter logic VS_POL     = 1'b1
) (
   input  logic       I_clk_1x,
   input  logic       I_rst,
   input  logic       I_enable,
   input  logic [7:0] I_R_data_o,
   input  logic [7:0] I_G_data_o,
   input  logic [7:0] I_B_data_o,
   input  logic [7:0] I_R_data_e,
   input  logic [7:0] I_G_data_e,
   input  logic [7:0] I_B_data_e,
   input  logic       I_DE,
   input  logic       I_VS,
   input  logic       I_HS,
   output logic [7:0] O_R_data_o,
   output logic [7:0] O_G_data_o,
   output logic [7:0] O_B_data_o,
   output logic [7:0] O_R_data_e,
   output logic [7:0] O_G_data_e,
   output logic [7:0] O_B_data_e,
   output logic       O_DE,
   output logic       O_VS,
   output logic       O_HS,
   output logic       O_panel_vdd_en,
   output logic       O_lvds_en,
   output logic       O_bl_en,
   output logic [3:0] O_state,
   output logic       O_ready
);

   typedef enum logic [3:0] {
      ST_OFF     = 4'd0,
      ST_PWR_UP  = 4'd1,
      ST_LINK_UP = 4'd2,
      ST_SYNC    = 4'd3,
      ST_VID_UP  = 4'd4,
      ST_RUN     = 4'd5,
      ST_BL_DN   = 4'd6,
      ST_VID_DN  = 4'd7,
      ST_LINK_DN = 4'd8
   } state_t;

   state_t           state, next_state;
   logic [CNT_W-1:0] cnt, cnt_nxt;
   logic             timeout;
   logic             vs_act, vs_d, fe;
   logic             vdd_nxt, lvds_nxt, bl_nxt, video_on;

   // Entry value of the delay counter for each state; untimed states load 0.
   function automatic logic [CNT_W-1:0] load_val(input state_t s);
      case (s)
         ST_OFF:     load_val = CNT_W'(T_OFF_MIN - 1);
         ST_PWR_UP:  load_val = CNT_W'(T_VDD_LINK - 1);
         ST_LINK_UP: load_val = CNT_W'(T_LINK_VID - 1);
         ST_VID_UP:  load_val = CNT_W'(T_VID_BL - 1);
         ST_BL_DN:   load_val = CNT_W'(T_BL_VID - 1);
         ST_VID_DN:  load_val = CNT_W'(T_VID_LINK - 1);
         ST_LINK_DN: load_val = CNT_W'(T_LINK_VDD - 1);
         default:    load_val = '0;
      endcase
   endfunction

   assign vs_act  = (I_VS == VS_POL);
   assign fe      = vs_act & ~vs_d;
   assign timeout = (cnt == '0);

   always_comb begin
      next_state = state;
      case (state)
         ST_OFF:     if (timeout && I_enable) next_state = ST_PWR_UP;
         ST_PWR_UP:  if (!I_enable) next_state = ST_LINK_DN;
                     else if (timeout) next_state = ST_LINK_UP;
         ST_LINK_UP: if (!I_enable) next_state = ST_VID_DN;
                     else if (timeout) next_state = ST_SYNC;
         ST_SYNC:    if (!I_enable) next_state = ST_VID_DN;
                     else if (fe) next_state = ST_VID_UP;
         ST_VID_UP:  if (!I_enable) next_state = ST_BL_DN;
                     else if (timeout) next_state = ST_RUN;
         ST_RUN:     if (!I_enable) next_state = ST_BL_DN;
         ST_BL_DN:   if (timeout) next_state = ST_VID_DN;
         ST_VID_DN:  if (timeout) next_state = ST_LINK_DN;
         ST_LINK_DN: if (timeout) next_state = ST_OFF;
         default:    next_state = ST_LINK_DN;
      endcase

      cnt_nxt = timeout ? cnt : cnt - 1'b1;
      if (next_state != state)
         cnt_nxt = load_val(next_state);

      // Enables are decoded from the next state and registered, so they move exactly on state entry.
      vdd_nxt  = (next_state != ST_OFF);
      lvds_nxt = (next_state == ST_LINK_UP) || (next_state == ST_SYNC) ||
                 (next_state == ST_VID_UP)  || (next_state == ST_RUN)  ||
                 (next_state == ST_BL_DN)   || (next_state == ST_VID_DN);
      bl_nxt   = (next_state == ST_RUN);
      video_on = (next_state == ST_VID_UP) || (next_state == ST_RUN) ||
                 (next_state == ST_BL_DN);
   end

   always_ff @(posedge I_clk_1x) begin
      if (I_rst) begin
         state          <= ST_OFF;
         cnt            <= CNT_W'(T_OFF_MIN - 1);
         vs_d           <= 1'b0;
         O_panel_vdd_en <= 1'b0;
         O_lvds_en      <= 1'b0;
         O_bl_en        <= 1'b0;
         O_ready        <= 1'b0;
         O_R_data_o     <= '0;
         O_G_data_o     <= '0;
         O_B_data_o     <= '0;
         O_R_data_e     <= '0;
         O_G_data_e     <= '0;
         O_B_data_e     <= '0;
         O_DE           <= 1'b0;
         O_VS           <= 1'b0;
         O_HS           <= 1'b0;
      end else begin
         state          <= next_state;
         cnt            <= cnt_nxt;
         vs_d           <= vs_act;
         O_panel_vdd_en <= vdd_nxt;
         O_lvds_en      <= lvds_nxt;
         O_bl_en        <= bl_nxt;
         O_ready        <= (next_state == ST_RUN);
         // Gating uses the state the output cycle will be in, keeping video_on aligned with VID_UP entry.
         O_R_data_o     <= video_on ? I_R_data_o : 8'h00;
         O_G_data_o     <= video_on ? I_G_data_o : 8'h00;
         O_B_data_o     <= video_on ? I_B_data_o : 8'h00;
         O_R_data_e     <= video_on ? I_R_data_e : 8'h00;
         O_G_data_e     <= video_on ? I_G_data_e : 8'h00;
         O_B_data_e     <= video_on ? I_B_data_e : 8'h00;
         O_DE           <= video_on & I_DE;
         O_VS           <= lvds_nxt & I_VS;
         O_HS           <= lvds_nxt & I_HS;
      end
   end

   assign O_state = state;

endmodule

// File: tb/tb_lvds_panel_seq_ctrl.sv
// tb/tb_lvds_panel_seq_ctrl.sv - scoreboard bench for lvds_panel_seq_ctrl with T_*=4
module tb_lvds_panel_seq_ctrl;

   logic       clk = 1'b0;
   logic       rst;
   logic       en;
   logic [7:0] r_o, g_o, b_o, r_e, g_e, b_e;
   logic       de, vs, hs;
   logic [7:0] o_r_o, o_g_o, o_b_o, o_r_e, o_g_e, o_b_e;
   logic       o_de, o_vs, o_hs;
   logic       o_vdd, o_lvds, o_bl, o_ready;
   logic [3:0] o_state;

   int cyc = 0;
   int n_cmp = 0;
   int n_bad = 0;

   typedef struct {
      int          at;
      string       name;
      logic [26:0] val;
   } exp_t;

   exp_t sb[$];

   always #5 clk = ~clk;

   lvds_panel_seq_ctrl #(
      .T_VDD_LINK(4), .T_LINK_VID(4), .T_VID_BL(4), .T_BL_VID(4),
      .T_VID_LINK(4), .T_LINK_VDD(4), .T_OFF_MIN(4), .CNT_W(8), .VS_POL(1'b1)
   ) dut (
      .I_clk_1x(clk), .I_rst(rst), .I_enable(en),
      .I_R_data_o(r_o), .I_G_data_o(g_o), .I_B_data_o(b_o),
      .I_R_data_e(r_e), .I_G_data_e(g_e), .I_B_data_e(b_e),
      .I_DE(de), .I_VS(vs), .I_HS(hs),
      .O_R_data_o(o_r_o), .O_G_data_o(o_g_o), .O_B_data_o(o_b_o),
      .O_R_data_e(o_r_e), .O_G_data_e(o_g_e), .O_B_data_e(o_b_e),
      .O_DE(o_de), .O_VS(o_vs), .O_HS(o_hs),
      .O_panel_vdd_en(o_vdd), .O_lvds_en(o_lvds), .O_bl_en(o_bl),
      .O_state(o_state), .O_ready(o_ready)
   );

   // Cycle k = state after k non-reset rising edges.
   always @(posedge clk) begin
      if (rst) cyc <= 0;
      else     cyc <= cyc + 1;
   end

   function automatic logic [26:0] pack(input logic [3:0] st, input logic vdd, input logic lvds,
                                        input logic bl, input logic rdy, input logic d,
                                        input logic h, input logic v, input logic [7:0] r,
                                        input logic [7:0] b);
      return {st, vdd, lvds, bl, rdy, d, h, v, r, b};
   endfunction

   task automatic push(input int at, input string name, input logic [26:0] val);
      exp_t e;
      e.at = at; e.name = name; e.val = val;
      sb.push_back(e);
   endtask

   task automatic at_cyc(input int k);
      int guard = 0;
      while (cyc < k && guard < 1000) begin
         @(posedge clk);
         #1;
         guard++;
      end
   endtask

   // Monitor: compares the queue head whenever its cycle is presented.
   always @(negedge clk) begin
      logic [26:0] act;
      act = {o_state, o_vdd, o_lvds, o_bl, o_ready, o_de, o_hs, o_vs, o_r_o, o_b_e};
      while (sb.size() > 0 && sb[0].at == cyc) begin
         exp_t e;
         e = sb.pop_front();
         n_cmp++;
         if (act !== e.val) begin
            n_bad++;
            $display("FAIL %s @cyc %0d: got st=%0d vdd=%b lvds=%b bl=%b rdy=%b de=%b hs=%b vs=%b r=%h b=%h, want st=%0d vdd=%b lvds=%b bl=%b rdy=%b de=%b hs=%b vs=%b r=%h b=%h",
                     e.name, cyc, act[26:23], act[22], act[21], act[20], act[19], act[18], act[17], act[16],
                     act[15:8], act[7:0], e.val[26:23], e.val[22], e.val[21], e.val[20], e.val[19],
                     e.val[18], e.val[17], e.val[16], e.val[15:8], e.val[7:0]);
         end
      end
   end

   initial begin
      rst = 1'b1; en = 1'b1;
      r_o = 8'hA5; g_o = 8'h11; b_o = 8'h22;
      r_e = 8'h33; g_e = 8'h44; b_e = 8'h3C;
      de = 1'b1; hs = 1'b1; vs = 1'b0;

      // Power-up and frame-aligned video enable
      push(0,  "reset",        pack(4'd0, 0,0,0,0, 0,0,0, 8'h00, 8'h00));
      push(3,  "off_hold",     pack(4'd0, 0,0,0,0, 0,0,0, 8'h00, 8'h00));
      push(4,  "vdd_on",       pack(4'd1, 1,0,0,0, 0,0,0, 8'h00, 8'h00));
      push(8,  "lvds_on",      pack(4'd2, 1,1,0,0, 0,1,0, 8'h00, 8'h00));
      push(12, "sync_enter",   pack(4'd3, 1,1,0,0, 0,1,0, 8'h00, 8'h00));
      push(20, "sync_blank",   pack(4'd3, 1,1,0,0, 0,1,0, 8'h00, 8'h00));
      push(21, "vid_up",       pack(4'd4, 1,1,0,0, 1,1,1, 8'hA5, 8'h3C));
      push(24, "vid_up_end",   pack(4'd4, 1,1,0,0, 1,1,1, 8'hA5, 8'h3C));
      push(25, "run_bl_on",    pack(4'd5, 1,1,1,1, 1,1,1, 8'hA5, 8'h3C));
      push(27, "run_data",     pack(4'd5, 1,1,1,1, 1,0,0, 8'h5A, 8'hC3));
      push(30, "run_hold",     pack(4'd5, 1,1,1,1, 1,0,0, 8'h5A, 8'hC3));
      // Normal power-down (N=30) with re-enable in BL_DN at 32
      push(31, "bl_off",       pack(4'd6, 1,1,0,0, 1,0,0, 8'h5A, 8'hC3));
      push(34, "bl_dn_end",    pack(4'd6, 1,1,0,0, 1,0,0, 8'h5A, 8'hC3));
      push(35, "video_blank",  pack(4'd7, 1,1,0,0, 0,0,0, 8'h00, 8'h00));
      push(39, "lvds_off",     pack(4'd8, 1,0,0,0, 0,0,0, 8'h00, 8'h00));
      push(43, "vdd_off",      pack(4'd0, 0,0,0,0, 0,0,0, 8'h00, 8'h00));
      push(46, "off_min",      pack(4'd0, 0,0,0,0, 0,0,0, 8'h00, 8'h00));
      push(47, "repower",      pack(4'd1, 1,0,0,0, 0,0,0, 8'h00, 8'h00));
      // Abort in PWR_UP (enable dropped at 49)
      push(49, "pwr_up_mid",   pack(4'd1, 1,0,0,0, 0,0,0, 8'h00, 8'h00));
      push(50, "abort_linkdn", pack(4'd8, 1,0,0,0, 0,0,0, 8'h00, 8'h00));
      push(53, "linkdn_end",   pack(4'd8, 1,0,0,0, 0,0,0, 8'h00, 8'h00));
      push(54, "abort_off",    pack(4'd0, 0,0,0,0, 0,0,0, 8'h00, 8'h00));
      // Third power-up with VS held inactive
      push(57, "off_wait",     pack(4'd0, 0,0,0,0, 0,0,0, 8'h00, 8'h00));
      push(58, "pwr_up3",      pack(4'd1, 1,0,0,0, 0,0,0, 8'h00, 8'h00));
      push(66, "sync3",        pack(4'd3, 1,1,0,0, 0,0,0, 8'h00, 8'h00));
      push(71, "sync_hs",      pack(4'd3, 1,1,0,0, 0,1,0, 8'h00, 8'h00));
      push(100, "sync_stuck1", pack(4'd3, 1,1,0,0, 0,1,0, 8'h00, 8'h00));
      push(150, "sync_stuck2", pack(4'd3, 1,1,0,0, 0,1,0, 8'h00, 8'h00));

      repeat (3) @(posedge clk);
      #1 rst = 1'b0;

      at_cyc(20); vs = 1'b1;
      at_cyc(26); r_o = 8'h5A; b_e = 8'hC3; hs = 1'b0; vs = 1'b0;
      at_cyc(30); en = 1'b0;
      at_cyc(32); en = 1'b1;
      at_cyc(49); en = 1'b0;
      at_cyc(55); en = 1'b1;
      at_cyc(70); hs = 1'b1;
      at_cyc(152);

      if (sb.size() > 0) begin
         $display("FAIL scoreboard_drain: %0d entries left, required 0", sb.size());
         n_cmp += sb.size();
         n_bad += sb.size();
      end
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/lvds_panel_seq_ctrl.md
Name: lvds_panel_seq_ctrl

Overview:
- Power/link sequencer for the dual-channel 7:1 LVDS transmitter path.
- Sits between the video source and the dual-channel LVDS TX wrapper, in the odd-pixel 1x clock domain.
- Drives panel VDD enable, LVDS serializer enable and backlight enable in the panel-mandated order with programmable delays.
- Gates the odd/even RGB+DE stream: blanked (black, DE=0) until the link is up; switches to live video only on a frame boundary.

Parameters:
- T_VDD_LINK, 1000, cycles from VDD on to LVDS enable (T1)
- T_LINK_VID, 1000, cycles of blanked-but-timed output after LVDS enable, before waiting for frame boundary (T2)
- T_VID_BL, 2000, cycles of live video before backlight on (T3)
- T_BL_VID, 2000, cycles from backlight off to video blank (T4)
- T_VID_LINK, 1000, cycles of blanked output before LVDS disable (T5)
- T_LINK_VDD, 1000, cycles from LVDS disable to VDD off (T6)
- T_OFF_MIN, 5000, minimum cycles in OFF before a new power-up (T7)
- CNT_W, 24, delay counter width; every T_* must be >=1 and < 2^CNT_W
- VS_POL, 1, active level of I_VS; 1 = high

Ports:
- I_clk_1x  in  1  pixel clock (odd-channel 1x domain)
- I_rst  in  1  synchronous reset, active-high
- I_enable  in  1  level; 1 = panel on request, 0 = panel off request
- I_R_data_o / I_G_data_o / I_B_data_o  in  8 each  odd-pixel RGB
- I_R_data_e / I_G_data_e / I_B_data_e  in  8 each  even-pixel RGB
- I_DE / I_VS / I_HS  in  1 each  source timing
- O_R_data_o / O_G_data_o / O_B_data_o  out  8 each  gated odd RGB to TX wrapper
- O_R_data_e / O_G_data_e / O_B_data_e  out  8 each  gated even RGB to TX wrapper
- O_DE / O_VS / O_HS  out  1 each  gated timing to TX wrapper
- O_panel_vdd_en  out  1  panel power switch
- O_lvds_en  out  1  TX serializer/clock enable
- O_bl_en  out  1  backlight enable
- O_state  out  4  current FSM state code
- O_ready  out  1  1 only in RUN

Behaviour:
- Reset:
  - State OFF with counter loaded to T_OFF_MIN-1.
  - All enables 0, O_ready 0, all data outputs 0, O_DE/O_VS/O_HS 0.
- Datapath:
  - All data/timing outputs are registered: exactly 1 cycle latency from inputs.
  - HS/VS always pass through whenever O_lvds_en=1; otherwise forced 0.
  - RGB/DE pass through only when video_on=1; otherwise RGB=0, DE=0.
- Counter:
  - Single down-counter, loaded with T-1 on entry to each timed state; timeout when it reaches 0.
  - A timed state therefore lasts exactly T cycles.
- Frame edge: fe = I_VS transitions to its active level (VS_POL), detected with a 1-cycle delayed copy.
- States (code: outputs vdd/lvds/bl/video_on):
  - OFF (0: 0/0/0/0). Counts T_OFF_MIN. Exits to PWR_UP when timed out and I_enable=1; stays in OFF otherwise.
  - PWR_UP (1: 1/0/0/0). After T1 -> LINK_UP.
  - LINK_UP (2: 1/1/0/0). After T2 -> SYNC.
  - SYNC (3: 1/1/0/0). On fe -> VID_UP; video_on asserts in the same cycle state becomes VID_UP. Untimed (no timeout).
  - VID_UP (4: 1/1/0/1). After T3 -> RUN.
  - RUN (5: 1/1/1/1). O_ready=1.
  - BL_DN (6: 1/1/0/1). After T4 -> VID_DN.
  - VID_DN (7: 1/1/0/0). After T5 -> LINK_DN.
  - LINK_DN (8: 1/0/0/0). After T6 -> OFF, reloading T_OFF_MIN.
- Abort: I_enable=0 is sampled every cycle and overrides timeout in the same cycle.
  - RUN or VID_UP -> BL_DN.
  - LINK_UP or SYNC -> VID_DN.
  - PWR_UP -> LINK_DN.
- Power-down sequence runs to completion even if I_enable returns to 1; re-power-up only from OFF after T7.
- Enables change only on state entry; no glitches. Codes 9-15 are illegal and recover to LINK_DN.
- I_rst mid-sequence: all enables drop to 0 the next cycle (hard off is accepted).

Test Plan:
- Power-up, all T_*=4, T_OFF_MIN=4, I_enable=1 after reset:
  - vdd at cycle 4, lvds_en at 8.
  - SYNC entered at 12; with VS rising at 20, DE/RGB pass from the output at cycle 21.
  - bl_en at 25; O_ready=1.
- Datapath in RUN: I_R_data_o=0xA5, I_B_data_e=0x3C -> identical values on outputs 1 cycle later; in SYNC the same inputs -> outputs 0, DE 0, HS/VS follow inputs.
- Normal power-down: I_enable 1->0 in RUN at cycle N.
  - bl_en=0 at N+1; video blanked at N+5; lvds_en=0 at N+9; vdd=0 at N+13; O_state=0.
- Abort in PWR_UP: drop I_enable 2 cycles after vdd on -> LINK_DN, vdd=0 after T6; lvds_en never asserted.
- Re-enable during BL_DN: sequence continues to OFF; PWR_UP only after T_OFF_MIN elapses.
- No frame edge: VS held inactive -> FSM stays in SYNC indefinitely; bl_en=0 and DE=0 throughout.
